fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
- Instruction-fetch controller directly upstream of the instruction-side mem_system (memtype 0).
- Owns the PC. Issues one Rd request at a time and holds Addr stable until Done.
- Buffers a returned instruction while decode is stalled.
- Squashes in-flight fetches on branch/jump redirect and stops fetching after HALT.
- Feeds the IF/ID pipeline register.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- NOP_INSTR, 16'h0800, instruction presented to decode when no valid instruction is available.
- HALT_OP, 5'b00000, opcode in instr[15:11] that stops fetch.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- memAddr  out  16  fetch address to mem_system Addr
- memRd  out  1  read request to mem_system Rd
- memWr  out  1  tied 0
- memDataOut  in  16  mem_system DataOut
- memDone  in  1  mem_system Done
- memStall  in  1  mem_system Stall
- memErr  in  1  mem_system err
- stallIF  in  1  decode/hazard unit cannot accept an instruction this cycle
- redirect  in  1  taken branch/jump resolved; fetch from redirectPC
- redirectPC  in  16  redirect target, bit 0 ignored (forced 0)
- isBranchOut  out  1  redirect accepted this cycle; drives mem_system isBranch
- instrOut  out  16  instruction to IF/ID
- pcPlus2Out  out  16  PC of instrOut plus 2
- instrValid  out  1  instrOut is a real instruction
- halted  out  1  HALT fetched; no further requests
- err  out  1  sticky error

Behaviour:
- Reset, asynchronous, any state:
  - State IDLE; pc=RESET_PC; buffer empty.
  - memRd=0, memWr=0, memAddr=RESET_PC.
  - instrOut=NOP_INSTR, pcPlus2Out=0, instrValid=0, halted=0, err=0, isBranchOut=0.
- States: IDLE, REQ, HOLD, SQUASH, HALTED.
- IDLE:
  - Next cycle moves to REQ unless redirect is asserted; on redirect, pc<=redirectPC, then REQ.
- REQ:
  - memRd=1; memAddr=pc, constant for the whole request.
  - memDone=1 with redirect=0, stallIF=0:
    - instrOut=memDataOut, instrValid=1 in the same cycle (combinational pass-through of a hit or fill).
    - pc<=pc+2, modulo 2^16 (16'hFFFE wraps to 16'h0000).
    - Stay in REQ and issue the next fetch next cycle. Back-to-back hits give 1 instruction/cycle.
  - memDone=1 with stallIF=1: capture memDataOut and pc+2 into the holding buffer; go to HOLD.
  - Captured instruction has instr[15:11]==HALT_OP: deliver it normally, then go to HALTED instead of issuing another request.
- HOLD:
  - memRd=0; instrOut=buffer, instrValid=1.
  - When stallIF falls: pc<=buffered pc+2, go to REQ.
- Redirect:
  - Priority: redirect over stallIF over memDone.
  - In any non-HALTED state, the redirect cycle does the following:
    - instrValid=0; isBranchOut=1 for that cycle; pc<=redirectPC & 16'hFFFE; buffer cleared.
  - If a request is outstanding (REQ and memDone=0): go to SQUASH. Rd stays asserted with the old address, because mem_system requires Addr stable until Done.
  - Otherwise go to REQ.
  - Redirect in the same cycle as memDone: the returned data is discarded, then go to REQ.
- SQUASH:
  - memRd=1, old address, instrValid=0.
  - On memDone, discard data and go to REQ at the new pc.
  - A second redirect while in SQUASH updates pc only.
- HALTED:
  - memRd=0, halted=1, instrValid=0.
  - A redirect leaves HALTED (a mispredicted HALT) and behaves as above.
- Errors and invariants:
  - err sets on memErr and holds until reset.
  - Never asserts memRd in HOLD or HALTED.
  - memStall is used only for assertions: memAddr must not change while memStall=1.

Decomposition:
- Shared package fetch_pkg:
  - State encoding localparams: IDLE=3'd0, REQ=3'd1, HOLD=3'd2, SQUASH=3'd3, HALTED=3'd4.
  - NOP_INSTR, HALT_OP and RESET_PC defaults.
- One natural sub-module, fetch_buf: the 1-entry holding register (instr, pcPlus2, valid) with load and clear, built on the team dffe with asynchronous reset.
- PC register and adder stay inline.

Test Plan:
1. Reset, then an all-hit stub (Done same cycle as Rd), stallIF=0 -> memAddr sequence 0000,0002,0004,…; instrValid=1 every cycle; pcPlus2Out=memAddr+2.
2. Miss with Done after 4 cycles for address 0x0010 returning 16'hC123 -> memAddr stays 0x0010 for all 4 cycles; instrOut=16'hC123 with instrValid=1 on the Done cycle only.
3. Done with stallIF=1 for 3 cycles, data 16'h4A05 -> memRd=0 during the stall; instrOut held at 16'h4A05; the next request goes to pc+2 one cycle after stallIF falls.
4. Redirect to 0x0101 on cycle 2 of a 5-cycle miss at 0x0020 -> isBranchOut pulses 1 cycle; data at Done discarded (instrValid=0); next memAddr=0x0100.
5. HALT instruction 16'h0000 fetched at 0x0008 -> delivered with instrValid=1; halted=1 next cycle; memRd stays 0 for 20 cycles; a later redirect to 0x0040 resumes fetch.
6. PC at 0xFFFE with a hit -> next memAddr=0x0000. memErr pulse -> err=1 until rst; asynchronous rst mid-miss -> outputs at reset values immediately, before the next clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
// Exports: state_t encoding, reset PC / NOP / HALT defaults, opcode helper.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    HOLD   = 3'd2,
    SQUASH = 3'd3,
    HALTED = 3'd4
  } state_t;

  localparam logic [15:0] DEF_RESET_PC  = 16'h0000;
  localparam logic [15:0] DEF_NOP_INSTR = 16'h0800;
  localparam logic [4:0]  DEF_HALT_OP   = 5'b00000;

  function automatic logic is_op(
    input logic [15:0] instr,
    input logic [4:0]  op
  );
    return instr[15:11] == op;
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// One-entry holding register for an instruction returned while decode stalls.
// Ports: clk, rst, i_load/i_clear, i_instr/i_pcPlus2 in, o_instr/o_pcPlus2/o_valid out.
module fetch_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [15:0] i_instr,
  input  logic [15:0] i_pcPlus2,
  output logic [15:0] o_instr,
  output logic [15:0] o_pcPlus2,
  output logic        o_valid
);

  logic [15:0] r_instr;
  logic [15:0] r_pcPlus2;
  logic        r_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instr   <= '0;
      r_pcPlus2 <= '0;
      r_valid   <= 1'b0;
    end else if (i_clear) begin
      r_valid   <= 1'b0;
    end else if (i_load) begin
      r_instr   <= i_instr;
      r_pcPlus2 <= i_pcPlus2;
      r_valid   <= 1'b1;
    end
  end

  assign o_instr   = r_instr;
  assign o_pcPlus2 = r_pcPlus2;
  assign o_valid   = r_valid;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives mem_system, feeds IF/ID.
// Ports: clk/rst, mem* request/response, stallIF, redirect(+PC), instr/pc/valid out, halted, err.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [15:0] NOP_INSTR = DEF_NOP_INSTR,
  parameter logic [4:0]  HALT_OP   = DEF_HALT_OP
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] memAddr,
  output logic        memRd,
  output logic        memWr,
  input  logic [15:0] memDataOut,
  input  logic        memDone,
  input  logic        memStall,
  input  logic        memErr,
  input  logic        stallIF,
  input  logic        redirect,
  input  logic [15:0] redirectPC,
  output logic        isBranchOut,
  output logic [15:0] instrOut,
  output logic [15:0] pcPlus2Out,
  output logic        instrValid,
  output logic        halted,
  output logic        err
);

  state_t      r_state;
  state_t      w_next;
  logic [15:0] r_pc;
  logic [15:0] w_pcNext;
  logic [15:0] r_addr;
  logic        r_err;

  logic [15:0] w_pcPlus2;
  logic [15:0] w_redirPC;
  logic        w_bufLoad;
  logic        w_bufClear;
  logic [15:0] w_bufInstr;
  logic [15:0] w_bufPc2;
  logic        w_bufValid;

  assign w_pcPlus2 = r_pc + 16'd2;
  assign w_redirPC = redirectPC & 16'hFFFE;

  fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_bufLoad),
    .i_clear   (w_bufClear),
    .i_instr   (memDataOut),
    .i_pcPlus2 (w_pcPlus2),
    .o_instr   (w_bufInstr),
    .o_pcPlus2 (w_bufPc2),
    .o_valid   (w_bufValid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pcNext;
      r_err   <= r_err | memErr;
      // Snapshot of the address in flight; SQUASH keeps presenting it
      // while r_pc already points at the redirect target.
      if (r_state == REQ)
        r_addr <= r_pc;
    end
  end

  always_comb begin
    w_next      = r_state;
    w_pcNext    = r_pc;
    w_bufLoad   = 1'b0;
    w_bufClear  = 1'b0;
    memRd       = 1'b0;
    isBranchOut = 1'b0;
    instrOut    = NOP_INSTR;
    pcPlus2Out  = '0;
    instrValid  = 1'b0;
    halted      = 1'b0;

    if (redirect) begin
      isBranchOut = 1'b1;
      w_pcNext    = w_redirPC;
      w_bufClear  = 1'b1;
    end

    unique case (r_state)
      IDLE: begin
        w_next = REQ;
      end
      REQ: begin
        memRd = 1'b1;
        if (redirect) begin
          w_next = memDone ? REQ : SQUASH;
        end else if (memDone) begin
          instrOut   = memDataOut;
          instrValid = 1'b1;
          pcPlus2Out = w_pcPlus2;
          if (stallIF) begin
            w_bufLoad = 1'b1;
            w_next    = HOLD;
          end else begin
            w_pcNext = w_pcPlus2;
            w_next   = is_op(memDataOut, HALT_OP) ? HALTED : REQ;
          end
        end
      end
      HOLD: begin
        if (redirect) begin
          w_next = REQ;
        end else begin
          instrOut   = w_bufValid ? w_bufInstr : NOP_INSTR;
          pcPlus2Out = w_bufPc2;
          instrValid = w_bufValid;
          if (!stallIF) begin
            w_pcNext   = w_bufPc2;
            w_bufClear = 1'b1;
            w_next     = is_op(w_bufInstr, HALT_OP) ? HALTED : REQ;
          end
        end
      end
      SQUASH: begin
        memRd = 1'b1;
        if (memDone)
          w_next = REQ;
      end
      HALTED: begin
        halted = 1'b1;
        if (redirect)
          w_next = REQ;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign memAddr = (r_state == SQUASH) ? r_addr : r_pc;
  assign memWr   = 1'b0;
  assign err     = r_err;

  // mem_system needs Addr held for as long as it is stalling on a request.
  a_addr_stable: assert property (
    @(posedge clk) disable iff (rst)
    (memStall && !memDone) |=> $stable(memAddr)
  );

endmodule
